// File: rtl/dense_feeder_pkg.sv
// Shared types, constants and the result saturation helper for the dense feeder.
package dense_feeder_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_FIRE = 3'd2,
        S_WAIT = 3'd3,
        S_ACC  = 3'd4,
        S_OUT  = 3'd5
    } state_e;

    // Depth of the densing line/filter window; every chunk shifts exactly this many entries.
    localparam int TAPS = 9;

    // Widths of the accumulator and of the presented result word.
    localparam int SAT_OUT_W = 16;
    localparam int SAT_IN_W  = SAT_OUT_W + 8;

    // Clamp a signed accumulator to the signed result range. The value fits when all
    // bits from the result sign bit upward agree; otherwise pick the rail by the sign.
    function automatic logic [SAT_OUT_W-1:0] sat_acc(input logic [SAT_IN_W-1:0] v);
        logic [SAT_IN_W-SAT_OUT_W:0] hi_bits;
        hi_bits = v[SAT_IN_W-1:SAT_OUT_W-1];
        if ((~|hi_bits) || (&hi_bits)) begin
            sat_acc = v[SAT_OUT_W-1:0];
        end else if (v[SAT_IN_W-1]) begin
            sat_acc = {1'b1, {(SAT_OUT_W-1){1'b0}}};
        end else begin
            sat_acc = {1'b0, {(SAT_OUT_W-1){1'b1}}};
        end
    endfunction

endpackage

// File: rtl/dense_feeder_sat.sv
// Combinational saturator from the wide accumulator down to the signed result word.
module dense_sat
    import dense_feeder_pkg::*;
(
    input  logic [SAT_IN_W-1:0]  acc_i,
    output logic [SAT_OUT_W-1:0] res_o
);

    // Pure clamp; no state.
    always_comb begin
        res_o = sat_acc(acc_i);
    end

endmodule

// File: rtl/dense_feeder.sv
// Sequencer feeding one fully-connected neuron through the densing line/filter
// shift interface in 9-tap chunks, accumulating the per-chunk MAC results.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | shifting 9 entries: zero pads first, then jointly handshaken stream data
// FIRE   | one-cycle mac_enable with dense_valid = taps in this chunk
// WAIT   | MAC_LAT cycles for the densing result
// ACC    | add sign-extended MAC result, step remaining count
// OUT    | present saturated result until accepted
module dense_feeder
    import dense_feeder_pkg::*;
#(
    parameter int WID_PE_BITS = 16,
    parameter int WID_FILTER  = 16,
    parameter int ADDR_FIFO   = 10,
    parameter int CNT_W       = 12,
    parameter int MAC_LAT     = 2,
    parameter int ACC_W       = WID_PE_BITS + 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_W-1:0]       num_inputs,
    input  logic [WID_PE_BITS-1:0] act_data,
    input  logic                   act_valid,
    output logic                   act_ready,
    input  logic [WID_FILTER-1:0]  wgt_data,
    input  logic                   wgt_valid,
    output logic                   wgt_ready,
    output logic                   shifting_line,
    output logic                   line_buffer_reset,
    output logic [ADDR_FIFO-1:0]   row_length,
    output logic [WID_PE_BITS-1:0] input_line,
    output logic                   shifting_filter,
    output logic [WID_FILTER-1:0]  input_filter,
    output logic [7:0]             dense_valid,
    output logic                   mac_enable,
    input  logic [WID_PE_BITS-1:0] out_dense_data,
    output logic                   busy,
    output logic [WID_PE_BITS-1:0] res_data,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   done
);

    localparam int WAIT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT + 1) : 1;

    state_e                 state_q;
    logic [CNT_W-1:0]       rem_q;
    logic [3:0]             slot_q;
    logic [WAIT_W-1:0]      wait_q;
    logic [ACC_W-1:0]       acc_q;
    logic [7:0]             dense_valid_q;
    logic                   mac_enable_q;
    logic                   res_valid_q;
    logic [WID_PE_BITS-1:0] res_data_q;

    logic [3:0]             chunk_k;
    logic [3:0]             pad_slots;
    logic                   real_slot;
    logic                   pad_slot;
    logic                   joint_hs;
    logic                   shift_now;
    logic [ACC_W-1:0]       dout_ext;
    logic [ACC_W-1:0]       acc_sum;
    logic [WID_PE_BITS-1:0] sat_res;

    // Chunk geometry and the stream/shift handshake; real slots sit at the end of the window.
    always_comb begin
        chunk_k   = (rem_q >= CNT_W'(TAPS)) ? 4'(TAPS) : rem_q[3:0];
        pad_slots = 4'(TAPS) - chunk_k;
        real_slot = (state_q == S_LOAD) && (slot_q >= pad_slots);
        pad_slot  = (state_q == S_LOAD) && !real_slot;
        joint_hs  = real_slot && act_valid && wgt_valid;
        shift_now = pad_slot || joint_hs;
        dout_ext  = {{(ACC_W-WID_PE_BITS){out_dense_data[WID_PE_BITS-1]}}, out_dense_data};
        acc_sum   = acc_q + dout_ext;
    end

    dense_sat u_sat (
        .acc_i (acc_sum),
        .res_o (sat_res)
    );

    // Each stream's ready waits on the other's valid so both are consumed in the same cycle.
    always_comb begin
        act_ready         = real_slot && wgt_valid;
        wgt_ready         = real_slot && act_valid;
        shifting_line     = shift_now;
        shifting_filter   = shift_now;
        input_line        = joint_hs ? act_data : '0;
        input_filter      = joint_hs ? wgt_data : '0;
        line_buffer_reset = (state_q == S_IDLE) && start;
        row_length        = ADDR_FIFO'(1);
        busy              = (state_q != S_IDLE);
        dense_valid       = dense_valid_q;
        mac_enable        = mac_enable_q;
        res_valid         = res_valid_q;
        res_data          = res_data_q;
        done              = res_valid_q && res_ready;
    end

    // Sequencer state, counters, accumulator and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            rem_q         <= '0;
            slot_q        <= '0;
            wait_q        <= '0;
            acc_q         <= '0;
            dense_valid_q <= '0;
            mac_enable_q  <= 1'b0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
        end else begin
            mac_enable_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        rem_q  <= num_inputs;
                        acc_q  <= '0;
                        slot_q <= '0;
                        if (num_inputs == '0) begin
                            res_data_q  <= '0;
                            res_valid_q <= 1'b1;
                            state_q     <= S_OUT;
                        end else begin
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (shift_now) begin
                        if (slot_q == 4'(TAPS - 1)) begin
                            slot_q        <= '0;
                            mac_enable_q  <= 1'b1;
                            dense_valid_q <= 8'(chunk_k);
                            state_q       <= S_FIRE;
                        end else begin
                            slot_q <= slot_q + 4'd1;
                        end
                    end
                end
                S_FIRE: begin
                    wait_q  <= WAIT_W'(MAC_LAT - 1);
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_q == '0) begin
                        state_q <= S_ACC;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                S_ACC: begin
                    acc_q         <= acc_sum;
                    rem_q         <= rem_q - CNT_W'(chunk_k);
                    dense_valid_q <= '0;
                    if (rem_q == CNT_W'(chunk_k)) begin
                        res_data_q  <= sat_res;
                        res_valid_q <= 1'b1;
                        state_q     <= S_OUT;
                    end else begin
                        state_q <= S_LOAD;
                    end
                end
                S_OUT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        res_data_q  <= '0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
